// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with operand forwarding from EX/MEM and MEM/WB, plus stall/flush control.
// Optional: define ID_EX_PERF_EN to add stall_cnt / bubble_cnt performance counters.
module id_ex_reg #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            flush,
    input  logic            id_valid,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic [RA_W-1:0] id_rd,
    input  logic [XLEN-1:0] id_A,
    input  logic [XLEN-1:0] id_B,
    input  logic [XLEN-1:0] id_imm,
    input  logic            id_use_imm,
    input  logic [5:0]      id_opcode,
    input  logic            id_reg_write,
    input  logic            exmem_reg_write,
    input  logic [RA_W-1:0] exmem_rd,
    input  logic [XLEN-1:0] exmem_result,
    input  logic            memwb_reg_write,
    input  logic [RA_W-1:0] memwb_rd,
    input  logic [XLEN-1:0] memwb_result,
    output logic [XLEN-1:0] ID_EX_A,
    output logic [XLEN-1:0] ID_EX_B,
    output logic [5:0]      ID_EX_opcode,
    output logic [RA_W-1:0] ID_EX_rd,
    output logic            ID_EX_reg_write,
    output logic            ID_EX_valid
`ifdef ID_EX_PERF_EN
    ,
    output logic [31:0]     stall_cnt,
    output logic [31:0]     bubble_cnt
`endif
);

    localparam logic [5:0] OP_ADD = 6'b000000;

    // EX/MEM wins over MEM/WB; register x0 is never forwarded.
    function automatic logic [XLEN-1:0] fwd_operand(
        input logic [RA_W-1:0] rs,
        input logic [XLEN-1:0] rf_val,
        input logic            ex_we,
        input logic [RA_W-1:0] ex_rd,
        input logic [XLEN-1:0] ex_res,
        input logic            wb_we,
        input logic [RA_W-1:0] wb_rd,
        input logic [XLEN-1:0] wb_res
    );
        logic [XLEN-1:0] val;
        if ((rs != {RA_W{1'b0}}) && ex_we && (ex_rd == rs)) begin
            val = ex_res;
        end else if ((rs != {RA_W{1'b0}}) && wb_we && (wb_rd == rs)) begin
            val = wb_res;
        end else begin
            val = rf_val;
        end
        return val;
    endfunction

    logic [XLEN-1:0] a_d, a_q;
    logic [XLEN-1:0] b_d, b_q;
    logic [5:0]      opcode_d, opcode_q;
    logic [RA_W-1:0] rd_d, rd_q;
    logic            reg_write_d, reg_write_q;
    logic            valid_d, valid_q;
    logic [XLEN-1:0] fwd_a_s, fwd_b_s;

    // Forwarding muxes ahead of the pipeline flops.
    always_comb begin
        fwd_a_s = fwd_operand(id_rs1, id_A, exmem_reg_write, exmem_rd, exmem_result,
                              memwb_reg_write, memwb_rd, memwb_result);
        if (id_use_imm) begin
            fwd_b_s = id_imm;
        end else begin
            fwd_b_s = fwd_operand(id_rs2, id_B, exmem_reg_write, exmem_rd, exmem_result,
                                  memwb_reg_write, memwb_rd, memwb_result);
        end
    end

    // Next-state selection: flush beats stall, stall beats capture.
    always_comb begin
        a_d         = a_q;
        b_d         = b_q;
        opcode_d    = opcode_q;
        rd_d        = rd_q;
        reg_write_d = reg_write_q;
        valid_d     = valid_q;
        if (flush) begin
            a_d         = {XLEN{1'b0}};
            b_d         = {XLEN{1'b0}};
            opcode_d    = OP_ADD;
            rd_d        = {RA_W{1'b0}};
            reg_write_d = 1'b0;
            valid_d     = 1'b0;
        end else if (stall) begin
            a_d         = a_q;
            b_d         = b_q;
        end else begin
            a_d         = fwd_a_s;
            b_d         = fwd_b_s;
            opcode_d    = id_opcode;
            rd_d        = id_rd;
            reg_write_d = id_reg_write & id_valid;
            valid_d     = id_valid;
        end
    end

    // Pipeline state register; reset value equals the bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q         <= {XLEN{1'b0}};
            b_q         <= {XLEN{1'b0}};
            opcode_q    <= OP_ADD;
            rd_q        <= {RA_W{1'b0}};
            reg_write_q <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            opcode_q    <= opcode_d;
            rd_q        <= rd_d;
            reg_write_q <= reg_write_d;
            valid_q     <= valid_d;
        end
    end

    assign ID_EX_A         = a_q;
    assign ID_EX_B         = b_q;
    assign ID_EX_opcode    = opcode_q;
    assign ID_EX_rd        = rd_q;
    assign ID_EX_reg_write = reg_write_q;
    assign ID_EX_valid     = valid_q;

`ifdef ID_EX_PERF_EN
    logic [31:0] stall_cnt_d, stall_cnt_q;
    logic [31:0] bubble_cnt_d, bubble_cnt_q;

    // A bubble enters either by flush or by capturing an invalid slot.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (stall && !flush) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (flush || (!stall && !id_valid)) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end else begin
            bubble_cnt_d = bubble_cnt_q;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q  <= 32'd0;
            bubble_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: doc/id_ex_reg.md
# id_ex_reg

Pipeline register between the decode stage and the ALU. Captures decoded operands, opcode and destination on each clock, and resolves operand forwarding from the EX/MEM and MEM/WB stages before capture. Supports stall (hold) and flush (bubble insertion), and drives the ALU's `ID_EX_A`, `ID_EX_B` and opcode inputs directly from registers.

## Interface
Parameters:
- `XLEN`, 32, datapath width.
- `RA_W`, 5, register-address width.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk`, input, 1, rising-edge clock.
  - `rst_n`, input, 1, asynchronous active-low reset.
- Control:
  - `stall`, input, 1, hold all outputs this cycle.
  - `flush`, input, 1, load a bubble this cycle.
- Decode-stage inputs:
  - `id_valid`, input, 1, decode stage presents a real instruction.
  - `id_rs1`, `id_rs2`, input, `RA_W`, source register addresses.
  - `id_rd`, input, `RA_W`, destination register address.
  - `id_A`, `id_B`, input, `XLEN`, register-file read data.
  - `id_imm`, input, `XLEN`, sign-extended immediate.
  - `id_use_imm`, input, 1, select `id_imm` as operand B.
  - `id_opcode`, input, 6, ALU opcode.
  - `id_reg_write`, input, 1, instruction writes `id_rd`.
- Forwarding sources:
  - `exmem_reg_write`, input, 1, EX/MEM stage will write a register.
  - `exmem_rd`, input, `RA_W`, EX/MEM destination.
  - `exmem_result`, input, `XLEN`, EX/MEM result.
  - `memwb_reg_write`, input, 1, MEM/WB stage will write a register.
  - `memwb_rd`, input, `RA_W`, MEM/WB destination.
  - `memwb_result`, input, `XLEN`, MEM/WB result.
- Outputs (all registered):
  - `ID_EX_A`, `ID_EX_B`, output, `XLEN`, ALU operands.
  - `ID_EX_opcode`, output, 6, ALU opcode.
  - `ID_EX_rd`, output, `RA_W`, destination register.
  - `ID_EX_reg_write`, output, 1, write-enable passed downstream.
  - `ID_EX_valid`, output, 1, stage holds a real instruction.

## Operation
- Opcode encodings: ADD=6'b000000, SUB=000001, AND=000010, OR=000011, SLT=000100, MUL=000101. Other values pass through unchecked.
- Forwarding, per source operand X (rs1 uses `id_A`; rs2 uses `id_B`):
  - If `exmem_reg_write`, `exmem_rd`==rsX and rsX!=0, take `exmem_result`.
  - Else if `memwb_reg_write`, `memwb_rd`==rsX and rsX!=0, take `memwb_result`.
  - Else take the register-file value.
  - EX/MEM has priority when both sources match.
- Operand B: if `id_use_imm`=1, B=`id_imm` and forwarding on rs2 is ignored; otherwise B is the forwarded rs2 value.
- Per-cycle priority (highest first):
  - Reset.
  - `flush`: load a bubble. `flush` wins over `stall`.
  - `stall`: hold every output.
  - Otherwise capture the decode-stage inputs.
- Bubble contents: A=0, B=0, opcode=ADD, rd=0, reg_write=0, valid=0.
- On capture:
  - `ID_EX_valid`=`id_valid`.
  - `ID_EX_reg_write`=`id_reg_write & id_valid`. An invalid slot never writes.
  - A, B, opcode and rd are captured regardless of `id_valid`.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
- Forwarding muxes are combinational ahead of the flops. Forward sources are sampled in the same cycle as the `id_*` inputs.
- Reset (`rst_n`=0, asynchronous): all outputs go to 0 immediately, which is the bubble state. Reset asserted mid-stall or mid-flush also clears everything. Capture resumes on the first rising edge after `rst_n` rises.
- During a stall, forward sources keep changing but the held outputs do not change. The decode stage re-presents the instruction after the stall, and forwarding is re-evaluated at that point.
- No combinational path from any input to any output.

## Configuration
- `ID_EX_PERF_EN` defined: adds two 32-bit outputs, both wrapping at 2^32-1 to 0 and reset to 0.
  - `stall_cnt` increments every cycle with `stall`=1 and `flush`=0.
  - `bubble_cnt` increments every cycle a bubble is loaded, whether from `flush` or from capture with `id_valid`=0.
- `ID_EX_PERF_EN` undefined: the counter ports and logic are absent. All other behaviour is identical.

## Test plan
- **Reset:** assert `rst_n`=0 mid-run while outputs are non-zero → all outputs are 0 immediately, without waiting for a clock edge. After release, capture `id_A`=5, `id_B`=7, opcode ADD → next cycle A=5, B=7, opcode=000000, valid=1.
- **Forwarding priority:** `id_rs1`=3, `exmem_rd`=3 with result 0x11, `memwb_rd`=3 with result 0x22, both write-enables set → `ID_EX_A`=0x11. Repeat with `exmem_reg_write`=0 → `ID_EX_A`=0x22.
- **x0 and immediate:** `id_rs2`=0 with `exmem_rd`=0 and `exmem_reg_write`=1, `id_B`=0 → `ID_EX_B`=0. Then `id_use_imm`=1, `id_imm`=0xFFFFFFFC with an rs2 match present → `ID_EX_B`=0xFFFFFFFC.
- **Stall:** capture SUB with A=9, B=4, then assert `stall` for 3 cycles while all inputs change → outputs stay at SUB, 9, 4. On release, the new inputs are captured on the next edge.
- **Flush vs stall:** assert `stall`=1 and `flush`=1 in the same cycle → bubble loaded (valid=0, reg_write=0, opcode=ADD). With `ID_EX_PERF_EN` defined, `bubble_cnt` increments by 1 and `stall_cnt` is unchanged.
- **Invalid slot:** `id_valid`=0 with `id_reg_write`=1 → `ID_EX_reg_write`=0 and `ID_EX_valid`=0.
